// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial add/sub.
// z_o/n_o exist only when ADDSUB_SERIAL_FLAGS_EN is defined.
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             inv_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
  logic             v_o;
`ifdef ADDSUB_SERIAL_FLAGS_EN
  logic             z_o;
  logic             n_o;
`endif

  modport master (
    output start_i, inv_i, a_i, b_i,
    input  busy_o, done_o, s_o, c_o, v_o
`ifdef ADDSUB_SERIAL_FLAGS_EN
    , input z_o, n_o
`endif
  );

  modport slave (
    input  start_i, inv_i, a_i, b_i,
    output busy_o, done_o, s_o, c_o, v_o
`ifdef ADDSUB_SERIAL_FLAGS_EN
    , output z_o, n_o
`endif
  );
endinterface

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement adder/subtractor, LSB-first, one bit per clock.
// Define ADDSUB_SERIAL_FLAGS_EN to add zero (z_o) and negative (n_o) result flags.
//
// state | meaning
// IDLE  | waiting for start_i
// SHIFT | one full-adder bit per clock, WIDTH clocks
// DONE  | result valid for one cycle; start_i here restarts immediately
module addsub_serial #(
  parameter int WIDTH = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  addsub_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
`ifdef ADDSUB_SERIAL_FLAGS_EN
  logic             zacc_q, zacc_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
`endif

  logic             x_bit;
  logic             sum_bit;
  logic             cout;
  logic [WIDTH-1:0] shifted;

  assign x_bit   = b_q[0] ^ op_q;
  assign sum_bit = a_q[0] ^ x_bit ^ carry_q;
  assign cout    = (a_q[0] & x_bit) | (a_q[0] & carry_q) | (x_bit & carry_q);
  assign shifted = {sum_bit, acc_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
`ifdef ADDSUB_SERIAL_FLAGS_EN
    zacc_d  = zacc_q;
    z_d     = z_q;
    n_d     = n_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          op_d    = bus.inv_i;
          carry_d = bus.inv_i;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef ADDSUB_SERIAL_FLAGS_EN
          zacc_d  = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = cout;
        acc_d   = shifted[WIDTH-1:1];
        cnt_d   = cnt_q + CW'(1);
`ifdef ADDSUB_SERIAL_FLAGS_EN
        zacc_d  = zacc_q | sum_bit;
`endif
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB, so overflow needs no extra latch
          s_d     = shifted;
          c_d     = cout;
          v_d     = carry_q ^ cout;
`ifdef ADDSUB_SERIAL_FLAGS_EN
          z_d     = ~(zacc_q | sum_bit);
          n_d     = sum_bit;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef ADDSUB_SERIAL_FLAGS_EN
      zacc_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
`ifdef ADDSUB_SERIAL_FLAGS_EN
      zacc_q  <= zacc_d;
      z_q     <= z_d;
      n_q     <= n_d;
`endif
    end
  end

  assign bus.busy_o = (state_q == SHIFT);
  assign bus.done_o = (state_q == DONE);
  assign bus.s_o    = s_q;
  assign bus.c_o    = c_q;
  assign bus.v_o    = v_q;
`ifdef ADDSUB_SERIAL_FLAGS_EN
  assign bus.z_o    = z_q;
  assign bus.n_o    = n_q;
`endif
endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: expected results queued at issue,
// popped and compared by a monitor whenever done_o is seen.
module tb_addsub_serial;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(W)) bus_if();
  addsub_serial #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus_if));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic inv);
    exp_t e;
    int ua, ub, sa, sb, ur, r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (inv) begin
      ur  = ua - ub;
      r   = sa - sb;
      e.c = (ua >= ub);
    end else begin
      ur  = ua + ub;
      r   = sa + sb;
      e.c = (ur >= (1 << W));
    end
    e.s = ur[W-1:0];
    e.v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    e.z = (e.s == '0);
    e.n = e.s[W-1];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_if.done_o) begin
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got s=%h c=%0d v=%0d, no result expected", bus_if.s_o, bus_if.c_o, bus_if.v_o);
      end else begin
        e = q.pop_front();
        if (bus_if.s_o !== e.s || bus_if.c_o !== e.c || bus_if.v_o !== e.v
`ifdef ADDSUB_SERIAL_FLAGS_EN
            || bus_if.z_o !== e.z || bus_if.n_o !== e.n
`endif
           ) begin
          errors++;
          $display("FAIL result: got s=%h c=%0d v=%0d, expected s=%h c=%0d v=%0d (z=%0d n=%0d)",
                   bus_if.s_o, bus_if.c_o, bus_if.v_o, e.s, e.c, e.v, e.z, e.n);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic inv, input bit push);
    bus_if.start_i = 1'b1;
    bus_if.a_i     = a;
    bus_if.b_i     = b;
    bus_if.inv_i   = inv;
    if (push) q.push_back(model(a, b, inv));
  endtask

  task automatic wait_done(output int k, output int bcnt, output int hold_ok);
    logic [W-1:0] s0;
    s0 = bus_if.s_o;
    k = 0;
    bcnt = 0;
    hold_ok = 1;
    @(negedge clk);
    bus_if.start_i = 1'b0;
    while (!bus_if.done_o && k < 20) begin
      if (bus_if.busy_o) bcnt++;
      if (bus_if.s_o !== s0) hold_ok = 0;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic inv);
    int k, bc, h;
    issue(a, b, inv, 1'b1);
    wait_done(k, bc, h);
    check("latency", k, W);
    check("busy_cycles", bc, W);
    check("s_hold_during_shift", h, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(bus_if.busy_o), 0);
    check({tag, "_done"}, int'(bus_if.done_o), 0);
    check({tag, "_s"}, int'(bus_if.s_o), 0);
    check({tag, "_c"}, int'(bus_if.c_o), 0);
    check({tag, "_v"}, int'(bus_if.v_o), 0);
`ifdef ADDSUB_SERIAL_FLAGS_EN
    check({tag, "_z"}, int'(bus_if.z_o), 0);
    check({tag, "_n"}, int'(bus_if.n_o), 0);
`endif
  endtask

  initial begin
    int k, bc, h, d0;
    logic [W-1:0] ra, rb;
    logic ri;

    rst = 1'b1;
    bus_if.start_i = 1'b0;
    bus_if.inv_i   = 1'b0;
    bus_if.a_i     = '0;
    bus_if.b_i     = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed cases from IDLE, with a done-pulse width check after each
    run_op(8'h05, 8'h03, 1'b0);
    @(negedge clk);
    check("done_single_pulse", int'(bus_if.done_o), 0);
    run_op(8'h05, 8'h03, 1'b1);
    @(negedge clk);
    run_op(8'h03, 8'h05, 1'b1);
    @(negedge clk);
    run_op(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    run_op(8'h80, 8'h01, 1'b1);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0);
    @(negedge clk);

    // start_i at edges 3 and 5 of an operation in progress must be ignored
    issue(8'h12, 8'h34, 1'b0, 1'b1);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    repeat (2) @(negedge clk);
    issue(8'hAA, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    @(negedge clk);
    issue(8'hC3, 8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    k = 5;
    while (!bus_if.done_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ignored_start_latency", k, W);
    @(negedge clk);

    // back-to-back: start during DONE
    run_op(8'h21, 8'h13, 1'b0);
    issue(8'h40, 8'h41, 1'b1, 1'b1);
    wait_done(k, bc, h);
    check("b2b_done_spacing", k + 1, W + 1);
    @(negedge clk);

    // reset at edge 4 aborts with no done
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("abort");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt, d0);
    run_op(8'h09, 8'h04, 1'b1);

    // random operands, random idle gaps (0 gap = back-to-back)
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ri = 1'($urandom);
      run_op(ra, rb, ri);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
